// File: rtl/arm_defs.sv
// arm_defs: shared opcodes, shift codes, status-register bit indices and rotate helper
package arm_defs;
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;
   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;
   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
      return (v >> n) | (v << (6'd32 - 6'(n)));
   endfunction
endpackage

// File: rtl/exe_stage_reg.sv
// exe_stage_reg: EXE pipeline register; freeze holds, flush loads an all-zero bubble
module exe_stage_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         freeze,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // freeze wins over flush; a flush seen during freeze is dropped
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (!freeze) q <= flush ? '0 : d;
endmodule

// File: rtl/exe_module.sv
// exe_module: ARM execute stage - Val2 generation, ALU, status register, branch target
module exe_module
   import arm_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int SR_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             flush,
   input  logic             WB_EN_IN,
   input  logic             MEM_R_EN_IN,
   input  logic             MEM_W_EN_IN,
   input  logic [3:0]       EXE_CMD,
   input  logic             S,
   input  logic             B,
   input  logic             imm,
   input  logic [11:0]      Shift_operand,
   input  logic [23:0]      Signed_imm_24,
   input  logic [WIDTH-1:0] Val_Rn,
   input  logic [WIDTH-1:0] Val_Rm,
   input  logic [WIDTH-1:0] PC_IN,
   input  logic [3:0]       Dest_IN,
   output logic             WB_EN,
   output logic             MEM_R_EN,
   output logic             MEM_W_EN,
   output logic [WIDTH-1:0] ALU_result,
   output logic [WIDTH-1:0] Val_Rm_out,
   output logic [WIDTH-1:0] PC,
   output logic [3:0]       Dest,
   output logic             Branch_taken,
   output logic [WIDTH-1:0] Branch_Address,
   output logic [SR_W-1:0]  SR
);
   localparam int RW = 3 + 3 * WIDTH + 4;
   logic [4:0]       sh;
   logic [1:0]       st;
   logic [WIDTH-1:0] rm_asr, rm_sh, val2, alu_res;
   logic [WIDTH:0]   add_r, sub_r;
   logic             c_f, v_f, known;
   logic [SR_W-1:0]  new_sr;
   assign sh     = Shift_operand[11:7];
   assign st     = Shift_operand[6:5];
   assign rm_asr = $signed(Val_Rm) >>> sh;
   assign rm_sh  = st == SH_LSL ? Val_Rm << sh :
                   st == SH_LSR ? Val_Rm >> sh :
                   st == SH_ASR ? rm_asr : ror32(Val_Rm, sh);
   // memory offset beats rotated immediate, which beats the register shifter
   assign val2   = (MEM_R_EN_IN | MEM_W_EN_IN) ? {{(WIDTH-12){1'b0}}, Shift_operand} :
                   imm ? ror32({{(WIDTH-8){1'b0}}, Shift_operand[7:0]}, {Shift_operand[11:8], 1'b0}) :
                   rm_sh;
   // carry/borrow-in only applies to ADC/SBC, taken from the flags before this edge
   assign add_r  = {1'b0, Val_Rn} + {1'b0, val2} + {{WIDTH{1'b0}}, EXE_CMD == CMD_ADC && SR[SR_C]};
   assign sub_r  = {1'b0, Val_Rn} - {1'b0, val2} - {{WIDTH{1'b0}}, EXE_CMD == CMD_SBC && !SR[SR_C]};
   // ALU: result plus candidate flags; logical ops and unknown opcodes keep C and V
   always_comb begin
      alu_res = '0;
      c_f     = SR[SR_C];
      v_f     = SR[SR_V];
      known   = 1'b1;
      case (EXE_CMD)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD, CMD_ADC: begin
            alu_res = add_r[WIDTH-1:0];
            c_f     = add_r[WIDTH];
            v_f     = (Val_Rn[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != Val_Rn[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            alu_res = sub_r[WIDTH-1:0];
            c_f     = !sub_r[WIDTH];
            v_f     = (Val_Rn[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != Val_Rn[WIDTH-1]);
         end
         CMD_AND: alu_res = Val_Rn & val2;
         CMD_ORR: alu_res = Val_Rn | val2;
         CMD_EOR: alu_res = Val_Rn ^ val2;
         default: known = 1'b0;
      endcase
      new_sr       = SR;
      new_sr[SR_N] = known ? alu_res[WIDTH-1] : SR[SR_N];
      new_sr[SR_Z] = known ? alu_res == '0 : SR[SR_Z];
      new_sr[SR_C] = c_f;
      new_sr[SR_V] = v_f;
   end
   // status register: updates only on S while not stalled
   always_ff @(posedge clk or negedge rst)
      if (!rst) SR <= '0;
      else if (S && !freeze) SR <= new_sr;
   exe_stage_reg #(.W(RW)) u_reg (
      .clk    (clk),
      .rst    (rst),
      .freeze (freeze),
      .flush  (flush),
      .d      ({WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, alu_res, Val_Rm, PC_IN, Dest_IN}),
      .q      ({WB_EN, MEM_R_EN, MEM_W_EN, ALU_result, Val_Rm_out, PC, Dest})
   );
   assign Branch_taken   = B;
   assign Branch_Address = PC_IN + {{(WIDTH-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
endmodule
